// File: rtl/cordic_rotation_ctrl_if.sv
// Control/status bundle between the host, the CORDIC sequencer and the x/y datapath.
// The slave modport is the sequencer's view; the master is the host/datapath side.
interface cordic_rotation_ctrl_if #(
  parameter int W = 16
);
  logic                start;
  logic                abort;
  logic signed [W-1:0] angle_in;
  logic                ld;
  logic                delta;
  logic        [3:0]   i;
  logic signed [W-1:0] z;
  logic                busy;
  logic                done;
  logic                clamped;

  modport master (
    output start, abort, angle_in,
    input  ld, delta, i, z, busy, done, clamped
  );

  modport slave (
    input  start, abort, angle_in,
    output ld, delta, i, z, busy, done, clamped
  );
endinterface

// File: rtl/cordic_rotation_ctrl.sv
// Rotation-mode circular CORDIC sequencer: loads the datapath, steps the shift index
// and tracks the residual angle z through an arctangent table.
module cordic_rotation_ctrl #(
  parameter int W    = 16,
  parameter int ITER = 16
) (
  input  logic                  clk,
  input  logic                  async_rst,
  cordic_rotation_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  localparam logic        [3:0]   LAST_K = 4'(ITER - 1);
  localparam logic signed [W-1:0] Z_MAX  = W'(14280);
  localparam logic signed [W-1:0] Z_MIN  = -Z_MAX;

  state_t              r_state;
  state_t              w_next;
  logic        [3:0]   r_i;
  logic signed [W-1:0] r_z;
  logic                r_clamped;
  logic                w_ld;
  logic                w_busy;
  logic                w_done;
  logic                w_delta;
  logic                w_accept;
  logic                w_clampHit;
  logic signed [W-1:0] w_clampZ;
  logic signed [W-1:0] w_atan;

  // round(atan(2^-k) * 2^13); the last two entries round to zero
  function automatic logic signed [W-1:0] atanLut(input logic [3:0] k);
    case (k)
      4'd0:    atanLut = W'(6434);
      4'd1:    atanLut = W'(3798);
      4'd2:    atanLut = W'(2007);
      4'd3:    atanLut = W'(1019);
      4'd4:    atanLut = W'(511);
      4'd5:    atanLut = W'(256);
      4'd6:    atanLut = W'(128);
      4'd7:    atanLut = W'(64);
      4'd8:    atanLut = W'(32);
      4'd9:    atanLut = W'(16);
      4'd10:   atanLut = W'(8);
      4'd11:   atanLut = W'(4);
      4'd12:   atanLut = W'(2);
      4'd13:   atanLut = W'(1);
      default: atanLut = '0;
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_atan   = atanLut(r_i);

  always_comb begin
    w_clampZ   = bus.angle_in;
    w_clampHit = 1'b0;
    if (bus.angle_in > Z_MAX) begin
      w_clampZ   = Z_MAX;
      w_clampHit = 1'b1;
    end else if (bus.angle_in < Z_MIN) begin
      w_clampZ   = Z_MIN;
      w_clampHit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ld    = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_delta = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_ld   = 1'b1;
        w_busy = 1'b1;
        w_next = S_ITER;
      end
      S_ITER: begin
        w_busy  = 1'b1;
        w_delta = r_z[W-1];
        if (r_i == LAST_K) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Cancel beats any advance; in IDLE it simply drops a coincident start
    if (bus.abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_i       <= '0;
      r_z       <= '0;
      r_clamped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_z       <= w_clampZ;
            r_clamped <= w_clampHit;
            r_i       <= '0;
          end
        end
        S_ITER: begin
          if (bus.abort) begin
            r_i <= '0;
          end else begin
            r_z <= w_delta ? (r_z + w_atan) : (r_z - w_atan);
            if (r_i != LAST_K) r_i <= r_i + 4'd1;
          end
        end
        default: r_i <= '0;
      endcase
    end
  end

  assign bus.ld      = w_ld;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.delta   = w_delta;
  assign bus.i       = r_i;
  assign bus.z       = r_z;
  assign bus.clamped = r_clamped;

endmodule

// File: tb/tb_cordic_rotation_ctrl.sv
// Randomised self-checking bench for cordic_rotation_ctrl against a cycle-level
// behavioural model of the sequencer (clamp, then sign-driven atan subtraction).
module tb_cordic_rotation_ctrl;

  localparam int W    = 16;
  localparam int ITER = 16;

  logic clk = 1'b0;
  logic async_rst;

  cordic_rotation_ctrl_if #(.W(W)) bus ();

  cordic_rotation_ctrl #(.W(W), .ITER(ITER)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int atanTab[16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0};
  int zSeen[ITER];
  int lastZ  = 0;
  int lastCl = 0;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampAngle(input int a);
    if (a > 14280)  return 14280;
    if (a < -14280) return -14280;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag, input int zExp, input int clExp);
    checkOutput({tag, " ld"}, bus.ld, 0);
    checkOutput({tag, " busy"}, bus.busy, 0);
    checkOutput({tag, " done"}, bus.done, 0);
    checkOutput({tag, " delta"}, bus.delta, 0);
    checkOutput({tag, " i"}, bus.i, 0);
    checkOutput({tag, " z"}, bus.z, zExp);
    checkOutput({tag, " clamped"}, bus.clamped, clExp);
  endtask

  // One full operation; abortAt/startAt/resetAt select an iteration (-1 = never)
  task automatic applyStimulus(input int angle, input int abortAt, input int startAt,
                               input int resetAt);
    int zExp;
    int clExp;
    zExp  = clampAngle(angle);
    clExp = (angle > 14280 || angle < -14280) ? 1 : 0;
    bus.angle_in = W'(angle);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.angle_in = W'($urandom);
    checkOutput("load ld", bus.ld, 1);
    checkOutput("load busy", bus.busy, 1);
    checkOutput("load i", bus.i, 0);
    checkOutput("load delta", bus.delta, 0);
    checkOutput("load done", bus.done, 0);
    checkOutput("load z", bus.z, zExp);
    checkOutput("load clamped", bus.clamped, clExp);
    for (int k = 0; k < ITER; k++) begin
      tick();
      bus.start = 1'b0;
      checkOutput("iter ld", bus.ld, 0);
      checkOutput("iter busy", bus.busy, 1);
      checkOutput("iter done", bus.done, 0);
      checkOutput("iter i", bus.i, k);
      checkOutput("iter delta", bus.delta, (zExp < 0) ? 1 : 0);
      checkOutput("iter z", bus.z, zExp);
      zSeen[k] = zExp;
      if (k == abortAt) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        checkIdle("abort", zExp, clExp);
        lastZ  = zExp;
        lastCl = clExp;
        return;
      end
      if (k == resetAt) begin
        #3;
        async_rst = 1'b1;
        #1;
        checkIdle("async reset", 0, 0);
        #1;
        async_rst = 1'b0;
        tick();
        checkIdle("post reset", 0, 0);
        lastZ  = 0;
        lastCl = 0;
        return;
      end
      zExp = (zExp < 0) ? zExp + atanTab[k] : zExp - atanTab[k];
      bus.start = (k == startAt);
    end
    tick();
    bus.start = 1'b0;
    checkOutput("done pulse", bus.done, 1);
    checkOutput("done busy", bus.busy, 0);
    checkOutput("done ld", bus.ld, 0);
    checkOutput("done i", bus.i, ITER - 1);
    checkOutput("done delta", bus.delta, 0);
    checkOutput("done z", bus.z, zExp);
    tick();
    checkIdle("after done", zExp, clExp);
    lastZ  = zExp;
    lastCl = clExp;
  endtask

  initial begin
    int ang;
    int abortAt;
    int startAt;
    async_rst    = 1'b1;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    bus.angle_in = '0;
    #12;
    checkIdle("reset", 0, 0);
    async_rst = 1'b0;
    tick();
    checkIdle("idle", 0, 0);

    applyStimulus(0, -1, -1, -1);
    checkOutput("zero z1", zSeen[1], -6434);
    checkOutput("zero z2", zSeen[2], -2636);
    checkOutput("zero z3", zSeen[3], -629);
    checkOutput("zero z4", zSeen[4], 390);

    applyStimulus(6434, -1, -1, -1);
    checkOutput("pi4 z1", zSeen[1], 0);
    checkOutput("pi4 z2", zSeen[2], -3798);
    checkOutput("pi4 residual small", (lastZ <= 2 && lastZ >= -2) ? 1 : 0, 1);

    applyStimulus(3000, -1, 3, -1);
    applyStimulus(-3000, -1, -1, -1);

    applyStimulus(5000, -1, -1, 5);
    applyStimulus(5000, 5, -1, -1);
    applyStimulus(1234, -1, -1, -1);

    bus.start    = 1'b1;
    bus.abort    = 1'b1;
    bus.angle_in = W'(777);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkIdle("start+abort", lastZ, lastCl);
    tick();
    checkIdle("start+abort hold", lastZ, lastCl);

    applyStimulus(20000, -1, -1, -1);
    applyStimulus(-20000, -1, -1, -1);
    applyStimulus(100, -1, -1, -1);

    for (int n = 0; n < 40; n++) begin
      ang     = int'($urandom_range(40000)) - 20000;
      abortAt = ($urandom_range(7) == 0) ? int'($urandom_range(ITER - 1)) : -1;
      startAt = ($urandom_range(2) == 0) ? int'($urandom_range(ITER - 1)) : -1;
      applyStimulus(ang, abortAt, startAt, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
